alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle instruction sequencer for the 8-bit ALU / accumulator / carry-register datapath.
//  Fetches 12-bit instructions from a synchronous program ROM and decodes them.
//  Drives ALUCode, the R operand, Ci and the A_CE/CY_CE register enables.
//  Evaluates conditional jumps from the CY and accumulator flags. Sits between program ROM and datapath.
// PARAMETERS
//  PC_W        8      program-counter / ROM address width
//  DATA_W      8      operand width (matches ALU A/R)
//  RESET_PC    0      PC value loaded on Reset
//  ILLEGAL_HLT 0      1: illegal opcode halts the core; 0: illegal opcode executes as NOP
// PORTS
//  clk         in   1       rising-edge clock
//  Reset       in   1       asynchronous, active-high reset
//  run         in   1       level; 1 = fetch new instructions
//  imem_addr   out  PC_W    ROM address (registered PC)
//  imem_rdata  in   12      ROM data; valid 1 cycle after imem_addr is presented
//  A_q         in   DATA_W  accumulator output (used for zero flag)
//  CY_q        in   1       carry register output
//  ALUCode     out  3       ALU operation select
//  R           out  DATA_W  ALU R operand (= immediate)
//  Ci          out  1       ALU carry-in (= CY_q)
//  A_CE        out  1       accumulator load enable
//  CY_CE       out  1       carry register load enable
//  busy        out  1       1 whenever state != IDLE/HALT
//  halted      out  1       1 in HALT state
//  illegal     out  1       sticky; set on decode of opcode 0xD/0xE
// BEHAVIOUR
//  Instruction format: [11:8] op, [7:0] imm.
//  - op 0x0-0x7: ALU op; ALUCode=op[2:0], R=imm; A_CE=CY_CE=1 in EXEC.
//  - 0x8 JMP: PC<=imm. 0x9 JC: jump if CY_q=1. 0xA JNC: jump if CY_q=0.
//  - 0xB JZ: jump if A_q==0. 0xC NOP. 0xF HALT. 0xD/0xE illegal.
//  States: IDLE -> FETCH -> DECODE -> EXEC -> FETCH | IDLE | HALT.
//  - IDLE: hold; go to FETCH when run=1.
//  - FETCH: imem_addr=PC.
//  - DECODE: IR<=imem_rdata.
//  - EXEC: enables asserted; PC updated at exit.
//  - From EXEC: next is HALT on 0xF, or on 0xD/0xE with ILLEGAL_HLT=1; else FETCH if run=1, else IDLE.
//  Timing and outputs:
//  - 3 clocks per instruction; A_CE/CY_CE are single-cycle pulses, only in EXEC for ALU ops.
//  - Datapath registers capture on the EXEC->next edge.
//  - ALUCode, R and Ci are decoded from IR and valid throughout EXEC; they hold the IR value in other states.
//  Flags and PC:
//  - Branch flags are sampled in EXEC, so they reflect results of prior instructions only.
//  - PC <= PC+1 mod 2^PC_W (0xFF -> 0x00) unless a branch is taken; a taken branch loads imm[PC_W-1:0].
//  run deasserted mid-instruction: current instruction completes, then IDLE; PC retained; resume on run=1.
//  HALT: outputs idle, halted=1; exit only via Reset.
//  Reset, asynchronous, any state:
//  - state=IDLE, PC=RESET_PC, IR=0xC00 (NOP).
//  - A_CE=CY_CE=0, illegal=0, halted=0, busy=0, ALUCode=0, R=0.
//  - An instruction interrupted mid-EXEC produces no enable pulse after Reset asserts.
// TESTING
//  1 Reset, run=1, ROM[0]=0x205:
//    imem_addr=0 in FETCH; EXEC at clk 3 with ALUCode=2, R=0x05, A_CE=CY_CE=1 for exactly 1 cycle; PC=1.
//  2 ROM[1]=0x810 (JMP):
//    imem_addr=0x10 on next FETCH; A_CE/CY_CE stay 0.
//  3 Carry-conditional branches:
//    JC 0x40 with CY_q=1 -> PC=0x40; JC 0x40 with CY_q=0 -> PC=PC+1.
//    JNC behaves inversely; JZ with A_q=0x00 -> taken, A_q=0x01 -> not taken.
//  4 Wrap-around: NOP at 0xFF -> next imem_addr=0x00.
//    HALT (0xF00) -> halted=1, busy=0; run toggling has no effect until Reset.
//  5 Illegal opcode:
//    0xD00 with ILLEGAL_HLT=0 -> illegal=1 (sticky), execution continues at PC+1.
//    With ILLEGAL_HLT=1 -> HALT.
//  6 Control edge cases:
//    Drop run during DECODE -> instruction completes, then IDLE with PC held.
//    Assert Reset during EXEC -> A_CE=0 immediately, PC=RESET_PC.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit ALU/accumulator/carry datapath.
// Each instruction takes FETCH, DECODE and EXEC, one clock each; the datapath enables pulse in EXEC only.
module alu_seq_ctrl #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RESET_PC    = 0,
  parameter bit          ILLEGAL_HLT = 1'b0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [11:0]       imem_rdata,
  input  logic [DATA_W-1:0] A_q,
  input  logic              CY_q,
  output logic [2:0]        ALUCode,
  output logic [DATA_W-1:0] R,
  output logic              Ci,
  output logic              A_CE,
  output logic              CY_CE,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  // The state register is a named enum so checkers can bind to it directly.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [11:0]     ir;
  logic [3:0]      op;
  logic [7:0]      imm;
  logic            is_alu;
  logic            is_ill;
  logic            taken;
  logic            illegal_q;

  assign op     = ir[11:8];
  assign imm    = ir[7:0];
  assign is_alu = ~op[3];
  assign is_ill = (op == 4'hD) || (op == 4'hE);

  // Branch flags come straight from the datapath, so they reflect earlier instructions only.
  always_comb begin
    taken = 1'b0;
    case (op)
      4'h8:    taken = 1'b1;
      4'h9:    taken = CY_q;
      4'hA:    taken = ~CY_q;
      4'hB:    taken = (A_q == '0);
      default: taken = 1'b0;
    endcase
    pc_next = taken ? PC_W'(imm) : pc + PC_W'(1);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IR is loaded as DECODE ends, when the synchronous ROM data for the FETCH address is valid.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pc        <= PC_W'(RESET_PC);
      ir        <= 12'hC00;
      illegal_q <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        ir <= imem_rdata;
        if ((imem_rdata[11:8] == 4'hD) || (imem_rdata[11:8] == 4'hE)) begin
          illegal_q <= 1'b1;
        end
      end
      if (state == S_EXEC) begin
        pc <= pc_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if ((op == 4'hF) || (ILLEGAL_HLT && is_ill)) begin
          state_next = S_HALT;
        end else if (run) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // Enables depend on state alone, so an asynchronous Reset kills an EXEC pulse at once.
  always_comb begin
    imem_addr = pc;
    ALUCode   = is_alu ? op[2:0] : 3'd0;
    R         = DATA_W'(imm);
    Ci        = CY_q;
    A_CE      = 1'b0;
    CY_CE     = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    illegal   = illegal_q;
    case (state)
      S_FETCH, S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy  = 1'b1;
        A_CE  = is_alu;
        CY_CE = is_alu;
      end
      S_HALT:  halted = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: random instruction streams checked per phase against an
// instruction-level model of PC, enables, halt and sticky illegal flag.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        run;
  logic [7:0]  imem_addr, imem_addr1;
  logic [11:0] imem_rdata, imem_rdata1;
  logic [7:0]  A_q;
  logic        CY_q;
  logic [2:0]  ALUCode, ALUCode1;
  logic [7:0]  R, R1;
  logic        Ci, Ci1, A_CE, A_CE1, CY_CE, CY_CE1;
  logic        busy, busy1, halted, halted1, illegal, illegal1;

  logic [11:0] rom  [256];
  logic [11:0] rom1 [256];

  int errors = 0;
  int checks = 0;
  logic [7:0] m_pc;
  logic       m_illegal;

  logic [11:0] br_ins [6] = '{12'h940, 12'h940, 12'hA40, 12'hA40, 12'hB40, 12'hB40};
  logic        br_cy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0]  br_a   [6] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h00, 8'h01};

  alu_seq_ctrl #(.PC_W(8), .DATA_W(8), .RESET_PC(0), .ILLEGAL_HLT(1'b0)) dut (
    .clk(clk), .Reset(Reset), .run(run), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .A_q(A_q), .CY_q(CY_q), .ALUCode(ALUCode), .R(R), .Ci(Ci), .A_CE(A_CE), .CY_CE(CY_CE),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  alu_seq_ctrl #(.PC_W(8), .DATA_W(8), .RESET_PC(0), .ILLEGAL_HLT(1'b1)) dut1 (
    .clk(clk), .Reset(Reset), .run(run), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .A_q(A_q), .CY_q(CY_q), .ALUCode(ALUCode1), .R(R1), .Ci(Ci1), .A_CE(A_CE1), .CY_CE(CY_CE1),
    .busy(busy1), .halted(halted1), .illegal(illegal1)
  );

  // Clock / synchronous ROM models
  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata  <= rom[imem_addr];
    imem_rdata1 <= rom1[imem_addr1];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: where the program counter goes after one instruction
  function automatic logic [7:0] model_next_pc(input logic [11:0] instr, input logic cy,
                                               input logic [7:0] a, input logic [7:0] pc);
    logic [7:0] seq;
    seq = pc + 8'd1;
    case (instr[11:8])
      4'h8:    return instr[7:0];
      4'h9:    return cy ? instr[7:0] : seq;
      4'hA:    return cy ? seq : instr[7:0];
      4'hB:    return (a == 8'd0) ? instr[7:0] : seq;
      default: return seq;
    endcase
  endfunction

  // Driver: runs one instruction starting in FETCH, checks every phase and the state after EXEC
  task automatic run_instr(input logic [11:0] instr, input logic cy, input logic [7:0] a,
                           input bit drop_run);
    logic [3:0] op;
    logic [7:0] imm;
    logic [7:0] exp_pc;
    logic       exp_alu;
    logic       exp_halt;
    op       = instr[11:8];
    imm      = instr[7:0];
    exp_alu  = (op < 4'h8);
    exp_halt = (op == 4'hF);
    exp_pc   = model_next_pc(instr, cy, a, m_pc);
    rom[m_pc] = instr;
    CY_q = cy;
    A_q  = a;
    checks++;
    if (imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_addr: got %h expected %h (instr %h)", imem_addr, m_pc, instr);
    end
    checks++;
    if ({busy, A_CE, CY_CE} !== 3'b100) begin
      errors++;
      $display("FAIL fetch_ctrl: busy/A_CE/CY_CE got %b expected 100", {busy, A_CE, CY_CE});
    end
    @(negedge clk);
    if (drop_run) run = 1'b0;
    checks++;
    if ({busy, A_CE, CY_CE} !== 3'b100) begin
      errors++;
      $display("FAIL decode_ctrl: busy/A_CE/CY_CE got %b expected 100", {busy, A_CE, CY_CE});
    end
    @(negedge clk);
    checks++;
    if ({busy, A_CE, CY_CE} !== {1'b1, exp_alu, exp_alu}) begin
      errors++;
      $display("FAIL exec_enables: got %b expected %b (instr %h)", {busy, A_CE, CY_CE},
               {1'b1, exp_alu, exp_alu}, instr);
    end
    checks++;
    if (Ci !== cy) begin
      errors++;
      $display("FAIL exec_ci: got %b expected %b", Ci, cy);
    end
    if (exp_alu) begin
      checks++;
      if ({ALUCode, R} !== {op[2:0], imm}) begin
        errors++;
        $display("FAIL exec_alucode_r: got %h/%h expected %h/%h", ALUCode, R, op[2:0], imm);
      end
    end
    if ((op == 4'hD) || (op == 4'hE)) m_illegal = 1'b1;
    @(negedge clk);
    m_pc = exp_pc;
    if (exp_halt) begin
      checks++;
      if ({halted, busy, A_CE, CY_CE} !== 4'b1000) begin
        errors++;
        $display("FAIL halt_entry: halted/busy/A_CE/CY_CE got %b expected 1000",
                 {halted, busy, A_CE, CY_CE});
      end
    end else begin
      checks++;
      if ({halted, busy} !== {1'b0, run}) begin
        errors++;
        $display("FAIL post_state: halted/busy got %b expected %b", {halted, busy}, {1'b0, run});
      end
      checks++;
      if (imem_addr !== m_pc) begin
        errors++;
        $display("FAIL next_pc: got %h expected %h (instr %h cy %b a %h)", imem_addr, m_pc,
                 instr, cy, a);
      end
    end
    checks++;
    if (illegal !== m_illegal) begin
      errors++;
      $display("FAIL illegal_flag: got %b expected %b", illegal, m_illegal);
    end
  endtask

  // Reset with value checks; leaves the core in FETCH at RESET_PC with run=1
  task automatic test_reset();
    Reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_addr, A_CE, CY_CE, busy, halted, illegal} !== {8'h00, 5'b00000}) begin
      errors++;
      $display("FAIL reset_ctrl: addr/A_CE/CY_CE/busy/halted/illegal got %h/%b expected 00/00000",
               imem_addr, {A_CE, CY_CE, busy, halted, illegal});
    end
    checks++;
    if ({ALUCode, R} !== 11'd0) begin
      errors++;
      $display("FAIL reset_alucode_r: got %h/%h expected 0/00", ALUCode, R);
    end
    Reset = 1'b0;
    run   = 1'b1;
    m_pc      = 8'h00;
    m_illegal = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_basic();
    run_instr(12'h205, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
    run_instr(12'h810, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_alu_random();
    logic [11:0] ins;
    for (int i = 0; i < 16; i++) begin
      ins = {1'b0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
      run_instr(ins, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic test_branches();
    logic [11:0] ins;
    logic [7:0]  a;
    for (int i = 0; i < 6; i++) begin
      run_instr(br_ins[i], br_cy[i], br_a[i], 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      ins = {4'($urandom_range(8, 11)), 8'($urandom_range(0, 255))};
      a   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_instr(ins, 1'($urandom_range(0, 1)), a, 1'b0);
    end
  endtask

  task automatic test_wrap();
    run_instr(12'h8FF, 1'b0, 8'h11, 1'b0);
    run_instr(12'hC00, 1'b1, 8'h22, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(12'hD00, 1'b0, 8'h33, 1'b0);
    run_instr({4'hE, 8'($urandom_range(0, 255))}, 1'b1, 8'h00, 1'b0);
    run_instr(12'h1AA, 1'b0, 8'h44, 1'b0);
  endtask

  task automatic test_run_drop();
    logic [7:0] held;
    run_instr({1'b0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))}, 1'b1, 8'h10, 1'b1);
    held = m_pc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, A_CE, CY_CE, imem_addr} !== {3'b000, held}) begin
        errors++;
        $display("FAIL idle_hold: busy/A_CE/CY_CE/addr got %b/%h expected 000/%h",
                 {busy, A_CE, CY_CE}, imem_addr, held);
      end
    end
    run = 1'b1;
    @(negedge clk);
    run_instr(12'hC00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_exec();
    rom[m_pc] = 12'h4C3;
    CY_q = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (A_CE !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_exec: A_CE got %b expected 1", A_CE);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({A_CE, CY_CE, busy, imem_addr} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset_in_exec: A_CE/CY_CE/busy/addr got %b/%h expected 000/00",
               {A_CE, CY_CE, busy}, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({A_CE, CY_CE} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_pulse: A_CE/CY_CE got %b expected 00", {A_CE, CY_CE});
    end
    Reset = 1'b0;
    run   = 1'b1;
    m_pc      = 8'h00;
    m_illegal = 1'b0;
    @(negedge clk);
    run_instr(12'h301, 1'b0, 8'h01, 1'b0);
  endtask

  task automatic test_halt();
    run_instr(12'hF00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({halted, busy, A_CE, CY_CE, imem_addr} !== {4'b1000, m_pc}) begin
        errors++;
        $display("FAIL halt_hold: halted/busy/A_CE/CY_CE/addr got %b/%h expected 1000/%h",
                 {halted, busy, A_CE, CY_CE}, imem_addr, m_pc);
      end
    end
    test_reset();
  endtask

  task automatic test_illegal_halt();
    rom1[0] = 12'hD00;
    run_instr(12'hD00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({halted1, busy1, illegal1, A_CE1} !== 4'b1010) begin
        errors++;
        $display("FAIL illegal_halt: halted/busy/illegal/A_CE got %b expected 1010",
                 {halted1, busy1, illegal1, A_CE1});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 12'hC00;
      rom1[i] = 12'hC00;
    end
    Reset = 1'b1;
    run   = 1'b0;
    A_q   = 8'h00;
    CY_q  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_alu_basic();
    test_alu_random();
    test_branches();
    test_wrap();
    test_illegal();
    test_run_drop();
    test_reset_exec();
    test_halt();
    test_illegal_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
